// File: rtl/uart_boot_loader_if.sv
// uart_boot_loader_if: UART byte handshake and program-RAM write port used by
// the boot loader. The loader is the master: it consumes received bytes and
// transmitter completions, and drives the transmit byte and RAM write strobe.
interface uart_boot_loader_if #(
    parameter int ADDR_W = 16
) ();
    logic [7:0]        rx_data;
    logic              rx_done;
    logic              tx_done;
    logic [7:0]        tx_data;
    logic              transmit;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_data;
    logic              ram_we;

    modport master (
        input  rx_data, rx_done, tx_done,
        output tx_data, transmit, ram_addr, ram_data, ram_we
    );

    modport slave (
        output rx_data, rx_done, tx_done,
        input  tx_data, transmit, ram_addr, ram_data, ram_we
    );
endinterface

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: receives a framed program image from a UART
// (sync byte, little-endian length, payload, additive checksum), writes the
// payload into program RAM from BASE_ADDR upward, answers ACK/NAK, and keeps
// the CPU in reset until a frame has passed the checksum.
// Optional feature: define BOOT_ECHO_EN to echo every payload byte on the
// transmitter; ACK/NAK then wait for the echo in flight to finish.
module uart_boot_loader #(
    parameter int                ADDR_W         = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
    parameter logic [7:0]        SYNC_BYTE      = 8'hA5,
    parameter int                RST_CYCLES     = 16,
    parameter int                TIMEOUT_CYCLES = 5000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               trigger,
    uart_boot_loader_if.master bus,
    output logic               booting,
    output logic               cpu_rst,
    output logic               boot_rst,
    output logic               error
);
    localparam int          LEN_BYTES = (ADDR_W + 7) / 8;
    localparam int          LEN_W     = LEN_BYTES * 8;
    // Largest image that fits between BASE_ADDR and the top of RAM.
    localparam logic [63:0] MAX_LEN   = (64'd1 << ADDR_W) - 64'(BASE_ADDR);
    localparam logic [31:0] RST_LAST  = 32'(RST_CYCLES - 1);
    localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  LEN_LAST  = 4'(LEN_BYTES - 1);
    localparam logic [7:0]  ACK_BYTE  = 8'h06;
    localparam logic [7:0]  NAK_BYTE  = 8'h15;

    typedef enum logic [3:0] {
        S_POR,
        S_IDLE,
        S_BOOT_RST,
        S_WAIT_SYNC,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_ACK,
        S_WAIT_ACK,
        S_RELEASE,
        S_NAK,
        S_WAIT_NAK
    } state_t;

    state_t           state;
    logic [2:0]       trig_sq;
    logic             trig_rise;
    logic [31:0]      cnt;       // reset-pulse length, or idle time inside a frame
    logic [LEN_W-1:0] len;       // length being assembled, then bytes still to come
    logic [LEN_W-1:0] len_full;
    logic [3:0]       len_idx;
    logic [7:0]       sum;
    logic             tx_free;

`ifdef BOOT_ECHO_EN
    logic busy;
    assign tx_free = ~busy;
`else
    assign tx_free = 1'b1;
`endif

    // Two-flop synchroniser on trigger plus one delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) trig_sq <= '0;
        else        trig_sq <= {trig_sq[1:0], trigger};
    end

    assign trig_rise = trig_sq[1] & ~trig_sq[2];

    // Length is little-endian: each new byte enters at the top and shifts down.
    assign len_full = (len >> 8) | (LEN_W'(bus.rx_data) << (LEN_W - 8));

    // Frame-receive FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_POR;
            booting      <= 1'b0;
            cpu_rst      <= 1'b1;
            boot_rst     <= 1'b1;
            error        <= 1'b0;
            bus.transmit <= 1'b0;
            bus.ram_we   <= 1'b0;
            bus.tx_data  <= '0;
            bus.ram_data <= '0;
            bus.ram_addr <= BASE_ADDR;
            cnt          <= '0;
            len          <= '0;
            len_idx      <= '0;
            sum          <= '0;
`ifdef BOOT_ECHO_EN
            busy         <= 1'b0;
`endif
        end else begin
            // NOTE: strobes default low here; a later non-blocking assignment in
            // the same block wins, so a state only has to say when they pulse.
            bus.transmit <= 1'b0;
            bus.ram_we   <= 1'b0;
            // The address advances the cycle after each write.
            if (bus.ram_we) bus.ram_addr <= bus.ram_addr + ADDR_W'(1);
`ifdef BOOT_ECHO_EN
            if (bus.tx_done) busy <= 1'b0;
`endif
            case (state)
                S_POR: begin
                    if (cnt == RST_LAST) begin
                        cpu_rst  <= 1'b0;
                        boot_rst <= 1'b0;
                        cnt      <= '0;
                        state    <= S_IDLE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_IDLE: begin
                    if (trig_rise) begin
                        booting      <= 1'b1;
                        cpu_rst      <= 1'b1;
                        boot_rst     <= 1'b1;
                        error        <= 1'b0;
                        bus.ram_addr <= BASE_ADDR;
                        sum          <= '0;
                        cnt          <= '0;
                        state        <= S_BOOT_RST;
                    end
                end
                S_BOOT_RST: begin
                    if (cnt == RST_LAST) begin
                        boot_rst <= 1'b0;
                        state    <= S_WAIT_SYNC;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_WAIT_SYNC: begin
                    if (bus.rx_done && bus.rx_data == SYNC_BYTE) begin
                        len     <= '0;
                        len_idx <= '0;
                        cnt     <= '0;
                        state   <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (bus.rx_done) begin
                        cnt <= '0;
                        len <= len_full;
                        if (len_idx == LEN_LAST) begin
                            if (64'(len_full) > MAX_LEN) state <= S_NAK;
                            else if (len_full == '0)     state <= S_CSUM;
                            else                         state <= S_DATA;
                        end else begin
                            len_idx <= len_idx + 4'd1;
                        end
                    end else if (cnt == TO_LAST) begin
                        state <= S_NAK;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_DATA: begin
                    if (bus.rx_done) begin
                        cnt          <= '0;
                        bus.ram_we   <= 1'b1;
                        bus.ram_data <= bus.rx_data;
                        sum          <= sum + bus.rx_data;
                        len          <= len - LEN_W'(1);
                        if (len == LEN_W'(1)) state <= S_CSUM;
`ifdef BOOT_ECHO_EN
                        // An echo requested while the transmitter is busy is dropped.
                        if (!busy) begin
                            bus.tx_data  <= bus.rx_data;
                            bus.transmit <= 1'b1;
                            busy         <= 1'b1;
                        end
`endif
                    end else if (cnt == TO_LAST) begin
                        state <= S_NAK;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_CSUM: begin
                    if (bus.rx_done) begin
                        state <= (bus.rx_data == sum) ? S_ACK : S_NAK;
                    end else if (cnt == TO_LAST) begin
                        state <= S_NAK;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_ACK: begin
                    if (tx_free) begin
                        bus.tx_data  <= ACK_BYTE;
                        bus.transmit <= 1'b1;
                        state        <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    if (bus.tx_done) begin
                        booting <= 1'b0;
                        cnt     <= '0;
                        state   <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (cnt == RST_LAST) begin
                        cpu_rst <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_NAK: begin
                    if (tx_free) begin
                        bus.tx_data  <= NAK_BYTE;
                        bus.transmit <= 1'b1;
                        error        <= 1'b1;
                        state        <= S_WAIT_NAK;
                    end
                end
                S_WAIT_NAK: begin
                    // Partial data stays in RAM; the next frame starts over at BASE_ADDR.
                    if (bus.tx_done) begin
                        sum          <= '0;
                        bus.ram_addr <= BASE_ADDR;
                        state        <= S_WAIT_SYNC;
                    end
                end
                default: state <= S_POR;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: drives framed images into two loader instances
// (16-bit address at base 0, and 8-bit address at base F0) and scores RAM
// writes and transmitted bytes against queues filled as stimulus is sent.
`timescale 1ns/1ps
module tb_uart_boot_loader;
    localparam int RST_CYCLES = 16;
    localparam int TIMEOUT    = 100;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0, trigger = 1'b0;
    logic rst_n8 = 1'b0, trigger8 = 1'b0;
    logic booting, cpu_rst, boot_rst, error;
    logic booting8, cpu_rst8, boot_rst8, error8;

    int passed = 0;
    int total  = 0;

    wr_t        wr_q[$];
    wr_t        wr8_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] tx8_q[$];
    wr_t        exp_w, exp_w8;
    logic [7:0] exp_t, exp_t8;
    logic       we_prev = 1'b0, we8_prev = 1'b0, tx_prev = 1'b0, tx8_prev = 1'b0;

    uart_boot_loader_if #(.ADDR_W(16)) bus ();
    uart_boot_loader_if #(.ADDR_W(8))  bus8 ();

    uart_boot_loader #(
        .ADDR_W(16), .BASE_ADDR(16'h0000), .SYNC_BYTE(8'hA5),
        .RST_CYCLES(RST_CYCLES), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .trigger(trigger), .bus(bus),
        .booting(booting), .cpu_rst(cpu_rst), .boot_rst(boot_rst), .error(error)
    );

    uart_boot_loader #(
        .ADDR_W(8), .BASE_ADDR(8'hF0), .SYNC_BYTE(8'hA5),
        .RST_CYCLES(RST_CYCLES), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut8 (
        .clk(clk), .rst_n(rst_n8), .trigger(trigger8), .bus(bus8),
        .booting(booting8), .cpu_rst(cpu_rst8), .boot_rst(boot_rst8), .error(error8)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", passed, total);
        $fatal(1, "watchdog expired");
    end

    // Scoreboard for the 16-bit loader outputs, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.ram_we === 1'b1) begin
            total++;
            if (wr_q.size() == 0) begin
                $display("FAIL ram_write: unexpected write addr=%h data=%h", bus.ram_addr, bus.ram_data);
            end else begin
                exp_w = wr_q.pop_front();
                if ({bus.ram_addr, bus.ram_data} !== {exp_w.addr, exp_w.data})
                    $display("FAIL ram_write: got addr=%h data=%h expected addr=%h data=%h",
                             bus.ram_addr, bus.ram_data, exp_w.addr, exp_w.data);
                else passed++;
            end
            total++;
            if (we_prev !== 1'b0) $display("FAIL ram_we_width: ram_we high %0d cycles, expected 1", 2);
            else passed++;
        end
        if (bus.transmit === 1'b1) begin
            total++;
            if (tx_q.size() == 0) begin
                $display("FAIL tx_byte: unexpected transmit of %h", bus.tx_data);
            end else begin
                exp_t = tx_q.pop_front();
                if (bus.tx_data !== exp_t) $display("FAIL tx_byte: got %h expected %h", bus.tx_data, exp_t);
                else passed++;
            end
            total++;
            if (tx_prev !== 1'b0) $display("FAIL transmit_width: transmit high %0d cycles, expected 1", 2);
            else passed++;
        end
        we_prev = bus.ram_we;
        tx_prev = bus.transmit;
    end

    // Scoreboard for the 8-bit loader outputs.
    always @(negedge clk) begin
        if (bus8.ram_we === 1'b1) begin
            total++;
            if (wr8_q.size() == 0) begin
                $display("FAIL ram8_write: unexpected write addr=%h data=%h", bus8.ram_addr, bus8.ram_data);
            end else begin
                exp_w8 = wr8_q.pop_front();
                if ({8'h00, bus8.ram_addr, bus8.ram_data} !== {exp_w8.addr, exp_w8.data})
                    $display("FAIL ram8_write: got addr=%h data=%h expected addr=%h data=%h",
                             bus8.ram_addr, bus8.ram_data, exp_w8.addr, exp_w8.data);
                else passed++;
            end
            total++;
            if (we8_prev !== 1'b0) $display("FAIL ram8_we_width: ram_we high %0d cycles, expected 1", 2);
            else passed++;
        end
        if (bus8.transmit === 1'b1) begin
            total++;
            if (tx8_q.size() == 0) begin
                $display("FAIL tx8_byte: unexpected transmit of %h", bus8.tx_data);
            end else begin
                exp_t8 = tx8_q.pop_front();
                if (bus8.tx_data !== exp_t8) $display("FAIL tx8_byte: got %h expected %h", bus8.tx_data, exp_t8);
                else passed++;
            end
            total++;
            if (tx8_prev !== 1'b0) $display("FAIL transmit8_width: transmit high %0d cycles, expected 1", 2);
            else passed++;
        end
        we8_prev = bus8.ram_we;
        tx8_prev = bus8.transmit;
    end

    task automatic send_byte(input logic [7:0] b, input bit sel, input int gap);
        @(negedge clk);
        if (sel) begin bus8.rx_data = b; bus8.rx_done = 1'b1; end
        else     begin bus.rx_data  = b; bus.rx_done  = 1'b1; end
        @(negedge clk);
        bus.rx_done  = 1'b0;
        bus8.rx_done = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Sends sync, length, payload and checksum; expected writes are queued as sent.
    task automatic send_frame(input bit sel, input logic [7:0] payload[$], input logic [7:0] csum);
        logic [15:0] base;
        logic [15:0] n16;
        wr_t         w;
        base = sel ? 16'h00F0 : 16'h0000;
        n16  = 16'(payload.size());
        send_byte(8'hA5, sel, 3);
        send_byte(n16[7:0], sel, 3);
        if (!sel) send_byte(n16[15:8], sel, 3);
        foreach (payload[i]) begin
            w.addr = base + 16'(i);
            w.data = payload[i];
            if (sel) wr8_q.push_back(w); else wr_q.push_back(w);
            send_byte(payload[i], sel, 3);
        end
        send_byte(csum, sel, 0);
    endtask

    // Expects one reply byte, returns the cycles waited, then completes it with tx_done.
    task automatic respond_tx(input bit sel, input logic [7:0] exp, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        if (sel) tx8_q.push_back(exp); else tx_q.push_back(exp);
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            lat++;
            seen = sel ? bus8.transmit : bus.transmit;
        end
        if (!seen) begin
            total++;
            $display("FAIL tx_wait: no transmit within 400 cycles, expected byte %h", exp);
            if (sel) void'(tx8_q.pop_back()); else void'(tx_q.pop_back());
        end else begin
            repeat (2) @(negedge clk);
            if (sel) bus8.tx_done = 1'b1; else bus.tx_done = 1'b1;
            @(negedge clk);
            bus.tx_done  = 1'b0;
            bus8.tx_done = 1'b0;
        end
    endtask

    task automatic start_boot(input bit sel);
        int n;
        bit up;
        n  = 0;
        up = 1'b0;
        if (sel) trigger8 = 1'b1; else trigger = 1'b1;
        for (int i = 0; i < 20 && !up; i++) begin
            @(negedge clk);
            up = sel ? booting8 : booting;
        end
        total++;
        if (!up) $display("FAIL boot_start: booting=0 after trigger, expected 1");
        else passed++;
        total++;
        if ((sel ? error8 : error) !== 1'b0) $display("FAIL boot_error_clear: error=1 expected 0");
        else passed++;
        while (n < 40 && (sel ? boot_rst8 : boot_rst) === 1'b1) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (n != RST_CYCLES) $display("FAIL boot_rst_width: %0d cycles, expected %0d", n, RST_CYCLES);
        else passed++;
        trigger  = 1'b0;
        trigger8 = 1'b0;
    endtask

    // Called right after an ACK's tx_done: booting drops, cpu_rst stays for RST_CYCLES.
    task automatic check_release(input bit sel);
        int n;
        n = 0;
        total++;
        if ((sel ? booting8 : booting) !== 1'b0) $display("FAIL release_booting: booting=1 expected 0");
        else passed++;
        while (n < 40 && (sel ? cpu_rst8 : cpu_rst) === 1'b1) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (n != RST_CYCLES) $display("FAIL release_cpu_rst: held %0d cycles, expected %0d", n, RST_CYCLES);
        else passed++;
    endtask

    task automatic check_reset_values(input string tag);
        total++;
        if ({booting, cpu_rst, boot_rst, error, bus.transmit, bus.ram_we} !== 6'b011000)
            $display("FAIL %s_ctrl: booting/cpu_rst/boot_rst/error/transmit/ram_we=%b expected 011000",
                     tag, {booting, cpu_rst, boot_rst, error, bus.transmit, bus.ram_we});
        else passed++;
        total++;
        if ({bus.tx_data, bus.ram_data} !== 16'h0000)
            $display("FAIL %s_data: tx_data=%h ram_data=%h expected 00 00", tag, bus.tx_data, bus.ram_data);
        else passed++;
        total++;
        if (bus.ram_addr !== 16'h0000) $display("FAIL %s_addr: ram_addr=%h expected 0000", tag, bus.ram_addr);
        else passed++;
    endtask

    task automatic test_reset();
        int n;
        n = 0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        total++;
        if ({booting8, cpu_rst8, boot_rst8, bus8.ram_addr} !== {3'b011, 8'hF0})
            $display("FAIL reset8: booting/cpu_rst/boot_rst=%b ram_addr=%h expected 011 f0",
                     {booting8, cpu_rst8, boot_rst8}, bus8.ram_addr);
        else passed++;
        rst_n  = 1'b1;
        rst_n8 = 1'b1;
        while (n < 40 && cpu_rst === 1'b1) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (n != RST_CYCLES) $display("FAIL por_cpu_rst: high %0d cycles, expected %0d", n, RST_CYCLES);
        else passed++;
        total++;
        if ({booting, boot_rst} !== 2'b00) $display("FAIL por_done: booting/boot_rst=%b expected 00", {booting, boot_rst});
        else passed++;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_good_frame();
        logic [7:0] p[$];
        int lat;
        p = '{8'h11, 8'h22, 8'h33};
        start_boot(1'b0);
        send_frame(1'b0, p, 8'h66);
        respond_tx(1'b0, 8'h06, lat);
        total++;
        if (lat != 1) $display("FAIL ack_latency: %0d cycles after checksum, expected 1", lat);
        else passed++;
        check_release(1'b0);
    endtask

    task automatic test_bad_checksum();
        logic [7:0] p[$];
        int lat;
        p = '{8'h11, 8'h22, 8'h33};
        start_boot(1'b0);
        send_frame(1'b0, p, 8'h65);
        respond_tx(1'b0, 8'h15, lat);
        total++;
        if ({error, booting} !== 2'b11) $display("FAIL nak_state: error/booting=%b expected 11", {error, booting});
        else passed++;
        // A trigger edge while booting must not restart the load or clear error.
        trigger = 1'b1;
        repeat (8) @(negedge clk);
        trigger = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if ({error, booting, boot_rst} !== 3'b110)
            $display("FAIL trigger_ignored: error/booting/boot_rst=%b expected 110", {error, booting, boot_rst});
        else passed++;
        send_frame(1'b0, p, 8'h66);
        respond_tx(1'b0, 8'h06, lat);
        check_release(1'b0);
        total++;
        if (error !== 1'b1) $display("FAIL error_sticky: error=%b expected 1", error);
        else passed++;
    endtask

    task automatic test_ignore_and_empty();
        logic [7:0] p[$];
        int lat;
        start_boot(1'b0);
        send_byte(8'h00, 1'b0, 3);
        send_byte(8'hFF, 1'b0, 3);
        send_frame(1'b0, p, 8'h00);
        respond_tx(1'b0, 8'h06, lat);
        check_release(1'b0);
    endtask

    task automatic test_timeout();
        logic [7:0] p[$];
        wr_t w;
        int lat;
        start_boot(1'b0);
        send_byte(8'hA5, 1'b0, 3);
        send_byte(8'h02, 1'b0, 3);
        send_byte(8'h00, 1'b0, 3);
        w.addr = 16'h0000;
        w.data = 8'hAA;
        wr_q.push_back(w);
        send_byte(8'hAA, 1'b0, 0);
        respond_tx(1'b0, 8'h15, lat);
        total++;
        if (lat != TIMEOUT + 1) $display("FAIL timeout_nak: NAK after %0d cycles, expected %0d", lat, TIMEOUT + 1);
        else passed++;
        total++;
        if (error !== 1'b1) $display("FAIL timeout_error: error=%b expected 1", error);
        else passed++;
        send_frame(1'b0, p, 8'h00);
        respond_tx(1'b0, 8'h06, lat);
        check_release(1'b0);
    endtask

    task automatic test_len_bounds();
        logic [7:0] p[$];
        int lat;
        start_boot(1'b1);
        send_byte(8'hA5, 1'b1, 3);
        send_byte(8'd17, 1'b1, 0);
        respond_tx(1'b1, 8'h15, lat);
        total++;
        if ({error8, booting8} !== 2'b11) $display("FAIL len_overflow: error/booting=%b expected 11", {error8, booting8});
        else passed++;
        for (int i = 1; i <= 16; i++) p.push_back(8'(i));
        send_frame(1'b1, p, 8'h88);
        respond_tx(1'b1, 8'h06, lat);
        check_release(1'b1);
    endtask

    task automatic test_reset_mid_data();
        wr_t w;
        start_boot(1'b0);
        send_byte(8'hA5, 1'b0, 3);
        send_byte(8'h05, 1'b0, 3);
        send_byte(8'h00, 1'b0, 3);
        w.addr = 16'h0000; w.data = 8'h11; wr_q.push_back(w);
        send_byte(8'h11, 1'b0, 3);
        w.addr = 16'h0001; w.data = 8'h22; wr_q.push_back(w);
        send_byte(8'h22, 1'b0, 3);
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (RST_CYCLES + 4) @(negedge clk);
        total++;
        if ({booting, cpu_rst} !== 2'b00) $display("FAIL post_reset_por: booting/cpu_rst=%b expected 00", {booting, cpu_rst});
        else passed++;
    endtask

    initial begin
        bus.rx_data  = '0; bus.rx_done  = 1'b0; bus.tx_done  = 1'b0;
        bus8.rx_data = '0; bus8.rx_done = 1'b0; bus8.tx_done = 1'b0;
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_ignore_and_empty();
        test_timeout();
        test_len_bounds();
        test_reset_mid_data();
        repeat (4) @(negedge clk);
        total++;
        if (wr_q.size() + wr8_q.size() != 0)
            $display("FAIL writes_missing: %0d expected RAM writes never seen", wr_q.size() + wr8_q.size());
        else passed++;
        total++;
        if (tx_q.size() + tx8_q.size() != 0)
            $display("FAIL tx_missing: %0d expected transmits never seen", tx_q.size() + tx8_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Parametrised successor to the fixed-format serial bootloader.
- Receives a framed program image from the UART receiver and writes it byte-by-byte into program RAM at a configurable base address.
- Frame check: length header plus additive checksum; the block replies ACK or NAK over the UART transmitter.
- Holds the CPU in reset while loading; releases it only after a frame passes the check.
- Sits between the UART core, the RAM address/write mux and the CPU reset.

Parameters:
- ADDR_W, 16, RAM address width; the length field is LEN_BYTES = ceil(ADDR_W/8) bytes.
- BASE_ADDR, 0, first RAM address written.
- SYNC_BYTE, 8'hA5, frame start marker.
- RST_CYCLES, 16, width in clk cycles of the cpu_rst/boot_rst pulses.
- TIMEOUT_CYCLES, 5000000, maximum idle clocks between bytes inside a frame.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- trigger  in  1  level request to start loading (synchronised and edge-detected internally).
- rx_data  in  8  UART receive byte.
- rx_done  in  1  one-cycle pulse; rx_data valid.
- tx_done  in  1  one-cycle pulse; transmitter finished its byte.
- tx_data  out  8  byte to transmit.
- transmit  out  1  one-cycle transmit strobe.
- ram_addr  out  ADDR_W  RAM write address.
- ram_data  out  8  RAM write data.
- ram_we  out  1  one-cycle RAM write strobe.
- booting  out  1  high while the loader owns the RAM and UART.
- cpu_rst  out  1  CPU reset, active high.
- boot_rst  out  1  UART reset pulse at load start.
- error  out  1  sticky; set on NAK, cleared on next trigger.

Behaviour:
- Clocking: single clock domain clk; rst_n is asynchronous assert, active low.
- Reset values:
  - state = POR; booting = 0; cpu_rst = 1; boot_rst = 1.
  - transmit = 0; ram_we = 0; tx_data = 0; ram_data = 0; error = 0; ram_addr = BASE_ADDR.
- POR: count RST_CYCLES, then drop cpu_rst and boot_rst -> IDLE.
- IDLE: on a rising edge of the synchronised trigger:
  - booting = 1, cpu_rst = 1, boot_rst = 1 for RST_CYCLES, error = 0, ram_addr = BASE_ADDR -> WAIT_SYNC.
- While booting = 1, trigger is ignored.
- WAIT_SYNC: each rx_done with rx_data == SYNC_BYTE -> LEN. Any other byte is discarded. No timeout in this state.
- LEN: collects LEN_BYTES bytes, little-endian, into len.
  - If len > 2^ADDR_W - BASE_ADDR -> NAK, with no RAM write.
  - If len == 0 -> CSUM.
  - Otherwise -> DATA.
- DATA: on each rx_done:
  - Next cycle: ram_we = 1 for one cycle, with ram_data = rx_data and ram_addr = current address.
  - Address increments the cycle after the write.
  - sum = sum + byte, modulo 256.
  - After len bytes -> CSUM.
- CSUM: one byte. Equal to sum -> ACK; otherwise -> NAK.
  - An empty frame requires checksum 8'h00.
- ACK: tx_data = 8'h06 with a one-cycle transmit -> WAIT_ACK.
  - On tx_done: booting = 0, cpu_rst held for RST_CYCLES then 0 -> IDLE.
- NAK: tx_data = 8'h15 with a one-cycle transmit, error = 1.
  - On tx_done -> WAIT_SYNC. The RAM keeps any partial data; sum and address are reset.
- Timeout: in LEN, DATA or CSUM, a counter reloads on every rx_done. Reaching TIMEOUT_CYCLES -> NAK.
- rx_done during ACK/NAK/WAIT states is ignored.
- rst_n asserted mid-frame: immediately returns to POR values; the partial image is not released.
- Address arithmetic is ADDR_W-bit. The length check guarantees no wrap past the top of RAM.

Optional Feature:
- Macro: BOOT_ECHO_EN.
- Defined: each payload byte is echoed; transmit pulses with tx_data = byte one cycle after its rx_done.
  - A busy flag is set on the echo and cleared on tx_done.
  - ACK/NAK waits for the busy flag to clear before issuing.
  - The host must pace bytes slower than the transmitter; an echo requested while busy is dropped.
- Undefined: transmit only occurs for ACK/NAK.

Test Plan:
- Release rst_n: cpu_rst high exactly RST_CYCLES (16) cycles, then low; booting stays 0.
- Trigger; send A5, 03 00, 11 22 33, checksum 66:
  - RAM[0..2] = 11, 22, 33, each with a one-cycle ram_we.
  - tx_data 06 is sent; booting falls after tx_done; cpu_rst pulse follows.
- Same frame with checksum 65: NAK 15 is sent, error = 1, still booting.
  - A following valid frame is accepted with ACK.
- Bytes 00 FF before A5 are ignored. Frame A5, 00 00, 00 gives ACK with no ram_we.
- A5, 02 00, AA, then idle for TIMEOUT_CYCLES (bench sets 100): NAK after 100 cycles.
- With ADDR_W = 8 and BASE_ADDR = 8'hF0, length 17: NAK with zero writes. rst_n pulsed mid-DATA: all outputs return to reset values.
